// File: rtl/valid_data_link_if.sv
// Link bundle between the toggling source stage and the capturing sink stage.
// Carries the enables in, and the link, capture and transfer-count observation out.
// No flow control of its own: the enables are the only throttle.
interface valid_data_link_if #(
    parameter int DATA_W = 1,
    parameter int CNT_W  = 16
);
    logic              src_en;
    logic              snk_en;
    logic [DATA_W-1:0] link_data;
    logic              link_valid;
    logic [DATA_W-1:0] valid_data;
    logic              capture;
    logic [CNT_W-1:0]  xfer_cnt;

    modport master (
        output src_en,
        output snk_en,
        input  link_data,
        input  link_valid,
        input  valid_data,
        input  capture,
        input  xfer_cnt
    );

    modport slave (
        input  src_en,
        input  snk_en,
        output link_data,
        output link_valid,
        output valid_data,
        output capture,
        output xfer_cnt
    );
endinterface

// File: rtl/valid_data_link.sv
// Toggling source register feeding a sink that captures valid payloads; optional counter via VALID_DATA_LINK_CNT_EN.
// Latency: capture and valid_data update one cycle after the edge that sees link_valid=1 with snk_en=1.
// Backpressure: none; src_en stalls the source, snk_en gates capture, nothing propagates upstream.
module valid_data_link #(
    parameter int DATA_W = 1,
    parameter int CNT_W  = 16
) (
    input  logic               clk,
    input  logic               rst,
    valid_data_link_if.slave   link
);

    logic [1:0]        sync_q;
    logic              src_run;
    logic              snk_run;
    logic [DATA_W-1:0] link_data_q;
    logic              link_valid_q;
    logic [DATA_W-1:0] valid_data_q;
    logic              capture_q;
    logic              cap_fire;

    // Release is staged: the source may toggle from the second edge after rst
    // rises, the sink one edge later (the link cannot be valid before then anyway).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], 1'b1};
        end
    end

    assign src_run = sync_q[0];
    assign snk_run = sync_q[1];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            link_data_q  <= '0;
            link_valid_q <= 1'b0;
        end else if (src_run && link.src_en) begin
            link_data_q  <= ~link_data_q;
            link_valid_q <= ~link_valid_q;
        end
    end

    // Sink samples the pre-edge link, so a same-edge toggle never corrupts the capture.
    assign cap_fire = snk_run & link.snk_en & link_valid_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_data_q <= '0;
            capture_q    <= 1'b0;
        end else begin
            capture_q <= cap_fire;
            if (cap_fire) begin
                valid_data_q <= link_data_q;
            end
        end
    end

`ifdef VALID_DATA_LINK_CNT_EN
    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else if (cap_fire && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_q <= cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign link.xfer_cnt = cnt_q;
`else
    assign link.xfer_cnt = {CNT_W{1'b0}};
`endif

    assign link.link_data  = link_data_q;
    assign link.link_valid = link_valid_q;
    assign link.valid_data = valid_data_q;
    assign link.capture    = capture_q;

endmodule

// File: tb/tb_valid_data_link.sv
// Bench for valid_data_link: 8-bit/16-bit-count and 1-bit/2-bit-count instances share one stimulus stream.
// A parity/count model is compared every falling edge; literal checks pin the directed scenarios.
module tb_valid_data_link;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic src_en = 1'b0;
    logic snk_en = 1'b0;
    bit   cmp_on = 1'b0;

    int checks = 0;
    int errors = 0;

    valid_data_link_if #(.DATA_W(8), .CNT_W(16)) if8 ();
    valid_data_link_if #(.DATA_W(1), .CNT_W(2))  if1 ();

    assign if8.src_en = src_en;
    assign if8.snk_en = snk_en;
    assign if1.src_en = src_en;
    assign if1.snk_en = snk_en;

    valid_data_link #(.DATA_W(8), .CNT_W(16)) u_dut8 (.clk(clk), .rst(rst), .link(if8));
    valid_data_link #(.DATA_W(1), .CNT_W(2))  u_dut1 (.clk(clk), .rst(rst), .link(if1));

    initial forever #5 clk = ~clk;

    // Model: the link is just a parity bit (all payload bits move together),
    // plus the last captured value and how many captures happened since reset.
    int edges_rel = 0;
    bit lv = 1'b0;
    bit vd = 1'b0;
    bit cap = 1'b0;
    int ncap = 0;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            edges_rel = 0;
            lv = 1'b0;
            vd = 1'b0;
            cap = 1'b0;
            ncap = 0;
        end else begin : mdl
            bit live;
            live = (edges_rel >= 1);
            if (edges_rel < 2) edges_rel++;
            cap = live && snk_en && lv;
            if (cap) begin
                vd = lv;
                ncap++;
            end
            if (live && src_en) lv = ~lv;
        end
    end

    function automatic logic [63:0] xcnt(input int c, input int w);
`ifdef VALID_DATA_LINK_CNT_EN
        int mx;
        mx = (1 << w) - 1;
        return (c > mx) ? 64'(mx) : 64'(c);
`else
        return 64'd0;
`endif
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (cmp_on) begin
            chk("m_lv8",  64'(if8.link_valid), 64'(lv));
            chk("m_ld8",  64'(if8.link_data),  64'({8{lv}}));
            chk("m_vd8",  64'(if8.valid_data), 64'({8{vd}}));
            chk("m_cap8", 64'(if8.capture),    64'(cap));
            chk("m_cnt8", 64'(if8.xfer_cnt),   xcnt(ncap, 16));
            chk("m_lv1",  64'(if1.link_valid), 64'(lv));
            chk("m_ld1",  64'(if1.link_data),  64'(lv));
            chk("m_vd1",  64'(if1.valid_data), 64'(vd));
            chk("m_cap1", 64'(if1.capture),    64'(cap));
            chk("m_cnt1", 64'(if1.xfer_cnt),   xcnt(ncap, 2));
        end
    end

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ld8"},  64'(if8.link_data),  64'd0);
        chk({tag, "_lv8"},  64'(if8.link_valid), 64'd0);
        chk({tag, "_vd8"},  64'(if8.valid_data), 64'd0);
        chk({tag, "_cap8"}, 64'(if8.capture),    64'd0);
        chk({tag, "_cnt8"}, 64'(if8.xfer_cnt),   64'd0);
        chk({tag, "_ld1"},  64'(if1.link_data),  64'd0);
        chk({tag, "_lv1"},  64'(if1.link_valid), 64'd0);
        chk({tag, "_vd1"},  64'(if1.valid_data), 64'd0);
        chk({tag, "_cap1"}, 64'(if1.capture),    64'd0);
        chk({tag, "_cnt1"}, 64'(if1.xfer_cnt),   64'd0);
    endtask

    task automatic next_cycle();
        @(negedge clk);
        #1;
    endtask

    initial begin
        #12;
        chk_all_zero("rst");

        // Release between edges; e1 must not toggle, e2 must.
        @(negedge clk);
        src_en = 1'b1;
        snk_en = 1'b1;
        rst    = 1'b1;
        cmp_on = 1'b1;

        next_cycle();                                   // after e1
        chk("e1_lv8", 64'(if8.link_valid), 64'd0);
        chk("e1_ld8", 64'(if8.link_data),  64'h00);
        next_cycle();                                   // after e2
        chk("e2_lv8",  64'(if8.link_valid), 64'd1);
        chk("e2_ld8",  64'(if8.link_data),  64'hFF);
        chk("e2_cap8", 64'(if8.capture),    64'd0);
        next_cycle();                                   // after e3: first capture
        chk("e3_lv1",  64'(if1.link_valid), 64'd0);
        chk("e3_ld8",  64'(if8.link_data),  64'h00);
        chk("e3_cap8", 64'(if8.capture),    64'd1);
        chk("e3_vd8",  64'(if8.valid_data), 64'hFF);
        chk("e3_vd1",  64'(if1.valid_data), 64'd1);
        next_cycle();                                   // after e4
        chk("e4_cap1", 64'(if1.capture),    64'd0);
        chk("e4_lv1",  64'(if1.link_valid), 64'd1);
        chk("e4_vd8",  64'(if8.valid_data), 64'hFF);
        next_cycle();                                   // after e5
        chk("e5_cap1", 64'(if1.capture),    64'd1);
        chk("e5_cnt1", 64'(if1.xfer_cnt),   xcnt(2, 2));

        repeat (8) next_cycle();                        // after e13: 6 captures
        chk("c6_cnt1", 64'(if1.xfer_cnt), xcnt(6, 2));
        chk("c6_cnt8", 64'(if8.xfer_cnt), xcnt(6, 16));
        repeat (8) next_cycle();                        // after e21: 10 captures
        chk("c10_cnt1", 64'(if1.xfer_cnt), xcnt(10, 2));
        chk("c10_cnt8", 64'(if8.xfer_cnt), xcnt(10, 16));
        chk("c10_vd8",  64'(if8.valid_data), 64'hFF);

        // e22 leaves link_valid=1; freeze the source for 5 edges.
        @(negedge clk);
        chk("frz_lv8", 64'(if8.link_valid), 64'd1);
        src_en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            next_cycle();
            chk("frz_cap8", 64'(if8.capture),    64'd1);
            chk("frz_ld8",  64'(if8.link_data),  64'hFF);
            chk("frz_lv1",  64'(if1.link_valid), 64'd1);
        end
        chk("frz_cnt8", 64'(if8.xfer_cnt), xcnt(15, 16));
        chk("frz_cnt1", 64'(if1.xfer_cnt), xcnt(15, 2));

        // Async reset between edges while a capture would otherwise fire next edge.
        #1 rst = 1'b0;
        #1 chk_all_zero("arst");
        #1 rst = 1'b1;
        next_cycle();
        chk("arst_cap8", 64'(if8.capture),    64'd0);
        chk("arst_lv8",  64'(if8.link_valid), 64'd0);
        chk("arst_cnt8", 64'(if8.xfer_cnt),   64'd0);
        src_en = 1'b1;

        for (int i = 0; i < 800; i++) begin
            @(negedge clk);
            src_en = ($urandom_range(0, 3) != 0);
            snk_en = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 99) == 0) begin
                #2 rst = 1'b0;
                #2 rst = 1'b1;
            end
        end

        @(negedge clk);
        cmp_on = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
